// File: rtl/ttc_intr_arbiter16_if.sv
// ttc_intr_arbiter16_if
//  Bundles the arbiter's counter-side and software-side signals.
//  master : drives arb_en, cnt_intr_reg, vec_rd, err_clr (interrupt logic / CPU side)
//  slave  : the arbiter; drives clear_interrupt, irq, vec_valid, vec_cnt,
//           vec_status, busy, timeout_err
interface ttc_intr_arbiter16_if #(
  parameter int NUM_CNT = 3
);
  logic                 arb_en;
  logic [6*NUM_CNT-1:0] cnt_intr_reg;
  logic                 vec_rd;
  logic                 err_clr;
  logic [NUM_CNT-1:0]   clear_interrupt;
  logic                 irq;
  logic                 vec_valid;
  logic [1:0]           vec_cnt;
  logic [5:0]           vec_status;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output arb_en, cnt_intr_reg, vec_rd, err_clr,
    input  clear_interrupt, irq, vec_valid, vec_cnt, vec_status, busy, timeout_err
  );

  modport slave (
    input  arb_en, cnt_intr_reg, vec_rd, err_clr,
    output clear_interrupt, irq, vec_valid, vec_cnt, vec_status, busy, timeout_err
  );
endinterface

// File: rtl/ttc_intr_arbiter16.sv
// ttc_intr_arbiter16
//  Round-robin interrupt arbiter for up to four timer-counter interrupt blocks.
//  A pending counter is granted, its 6-bit interrupt register is snapshotted
//  into vec_status, irq is held until software reads the vector (vec_rd), then
//  the counter gets a one-cycle clear_interrupt pulse followed by a holdoff.
//  Ports:
//   pclk16      clock, rising edge
//   n_p_reset16 asynchronous active-low reset
//   arb         slave modport of ttc_intr_arbiter16_if (all bus signals)
//  All outputs are registered.
module ttc_intr_arbiter16 #(
  parameter int NUM_CNT     = 3,
  parameter int HOLDOFF     = 2,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic                       pclk16,
  input  logic                       n_p_reset16,
  ttc_intr_arbiter16_if.slave        arb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [3:0]  HOLD_LAST   = 4'(HOLDOFF - 1);
  localparam logic [15:0] TIMEOUT_VAL = 16'(ACK_TIMEOUT);
  localparam logic [1:0]  LAST_RST    = 2'(NUM_CNT - 1);

  state_t               state_r, state_nxt_s;
  logic [1:0]           last_grant_r;
  logic [3:0]           hold_cnt_r;
  logic [15:0]          to_cnt_r, to_nxt_s;
  logic                 to_hit_s;
  logic [3:0]           req_s;
  logic [1:0]           cand_s, pick_s;
  logic                 found_s;
  logic [5:0]           pick_stat_s;
  logic [NUM_CNT-1:0]   clear_nxt_s;
  logic                 irq_r, vec_valid_r, busy_r, timeout_err_r;
  logic [1:0]           vec_cnt_r;
  logic [5:0]           vec_status_r;
  logic [NUM_CNT-1:0]   clear_r;

  // Per-counter request: any interrupt bit set. Unused upper slots stay 0.
  always_comb begin
    req_s = 4'd0;
    for (int k = 0; k < NUM_CNT; k++) begin
      req_s[k] = |arb.cnt_intr_reg[6*k +: 6];
    end
  end

  // Round-robin pick: first requester after last_grant, wrapping at NUM_CNT.
  // Only consulted in IDLE, so the held-off counter (and everyone else) is
  // implicitly masked for the whole of HOLD.
  always_comb begin
    found_s     = 1'b0;
    pick_s      = 2'd0;
    cand_s      = 2'd0;
    pick_stat_s = 6'd0;
    for (int i = 1; i <= NUM_CNT; i++) begin
      cand_s = 2'((32'(last_grant_r) + i) % NUM_CNT);
      if (!found_s && req_s[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < NUM_CNT; k++) begin
      if (pick_s == 2'(k)) begin
        pick_stat_s = arb.cnt_intr_reg[6*k +: 6];
      end else begin
        pick_stat_s = pick_stat_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arb.arb_en && found_s) state_nxt_s = ST_PEND;
        else                       state_nxt_s = ST_IDLE;
      end
      ST_PEND: begin
        if (arb.vec_rd) state_nxt_s = ST_CLEAR;
        else            state_nxt_s = ST_PEND;
      end
      ST_CLEAR: state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) state_nxt_s = ST_IDLE;
        else                         state_nxt_s = ST_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Ack timer: to_cnt_r holds the 1-based index of the current PEND cycle,
  // so the error flag lands exactly on PEND cycle ACK_TIMEOUT.
  always_comb begin
    if (state_r != ST_PEND) begin
      to_nxt_s = 16'd1;
    end else if (to_cnt_r == 16'hFFFF) begin
      to_nxt_s = to_cnt_r;
    end else begin
      to_nxt_s = to_cnt_r + 16'd1;
    end
    to_hit_s = (TIMEOUT_VAL != 16'd0) && (state_nxt_s == ST_PEND) &&
               (to_nxt_s == TIMEOUT_VAL);
  end

  // Clear pulse goes to the counter whose vector was just acknowledged.
  always_comb begin
    clear_nxt_s = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      clear_nxt_s[k] = (state_nxt_s == ST_CLEAR) && (vec_cnt_r == 2'(k));
    end
  end

  // State, timers and registered outputs.
  always_ff @(posedge pclk16 or negedge n_p_reset16) begin
    if (!n_p_reset16) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= LAST_RST;
      hold_cnt_r    <= 4'd0;
      to_cnt_r      <= 16'd0;
      irq_r         <= 1'b0;
      vec_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      vec_cnt_r     <= 2'd0;
      vec_status_r  <= 6'd0;
      clear_r       <= '0;
    end else begin
      state_r     <= state_nxt_s;
      irq_r       <= (state_nxt_s == ST_PEND);
      vec_valid_r <= (state_nxt_s == ST_PEND);
      busy_r      <= (state_nxt_s != ST_IDLE);
      clear_r     <= clear_nxt_s;
      to_cnt_r    <= (state_nxt_s == ST_PEND) ? to_nxt_s : 16'd0;
      if (state_r == ST_IDLE && state_nxt_s == ST_PEND) begin
        vec_cnt_r    <= pick_s;
        vec_status_r <= pick_stat_s;
      end
      if (state_r == ST_PEND && arb.vec_rd) begin
        last_grant_r <= vec_cnt_r;
      end
      if (state_r == ST_HOLD) hold_cnt_r <= hold_cnt_r + 4'd1;
      else                    hold_cnt_r <= 4'd0;
      // A new timeout outranks a simultaneous clear request.
      if (to_hit_s)         timeout_err_r <= 1'b1;
      else if (arb.err_clr) timeout_err_r <= 1'b0;
    end
  end

  assign arb.clear_interrupt = clear_r;
  assign arb.irq             = irq_r;
  assign arb.vec_valid       = vec_valid_r;
  assign arb.vec_cnt         = vec_cnt_r;
  assign arb.vec_status      = vec_status_r;
  assign arb.busy            = busy_r;
  assign arb.timeout_err     = timeout_err_r;

endmodule

// File: tb/tb_ttc_intr_arbiter16.sv
module tb_ttc_intr_arbiter16;
  logic pclk16 = 1'b0;
  logic n_p_reset16 = 1'b0;
  int   n_vec = 0;
  int   n_mis = 0;
  logic [7:0] exp_grant[$];
  logic [2:0] exp_clr[$];
  logic [7:0] eg;
  logic [2:0] ec;
  logic       prev_vv = 1'b0;

  ttc_intr_arbiter16_if #(.NUM_CNT(3)) bus ();

  ttc_intr_arbiter16 #(.NUM_CNT(3), .HOLDOFF(2), .ACK_TIMEOUT(8)) dut (
    .pclk16      (pclk16),
    .n_p_reset16 (n_p_reset16),
    .arb         (bus.slave)
  );

  always #5 pclk16 = ~pclk16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected vector on every new grant and the expected
  // clear pattern on every clear pulse.
  always @(negedge pclk16) begin
    if (bus.vec_valid && !prev_vv) begin
      if (exp_grant.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL grant_unexpected: got cnt %0d status %0h, expected none", bus.vec_cnt, bus.vec_status);
      end else begin
        eg = exp_grant.pop_front();
        check("grant_vec", {24'd0, bus.vec_cnt, bus.vec_status}, {24'd0, eg});
        check("grant_irq", {31'd0, bus.irq}, 32'd1);
      end
    end
    if (bus.clear_interrupt != 3'd0) begin
      if (exp_clr.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL clear_unexpected: got %b, expected none", bus.clear_interrupt);
      end else begin
        ec = exp_clr.pop_front();
        check("clear_pulse", {29'd0, bus.clear_interrupt}, {29'd0, ec});
      end
    end
    prev_vv = bus.vec_valid;
  end

  task automatic wait_grant();
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk16);
      if (bus.vec_valid) break;
    end
    check("grant_wait", {31'd0, bus.vec_valid}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk16);
      if (!bus.busy) break;
    end
    check("idle_wait", {31'd0, bus.busy}, 32'd0);
  endtask

  // vec_rd high for exactly one sampling edge; returns just after that edge.
  task automatic pulse_ack();
    @(posedge pclk16); #1 bus.vec_rd = 1'b1;
    @(posedge pclk16); #1 bus.vec_rd = 1'b0;
  endtask

  task automatic grant_ack(input int k, input logic [5:0] stat, input logic [5:0] late);
    exp_grant.push_back({2'(k), stat});
    exp_clr.push_back(3'(1 << k));
    wait_grant();
    // Bits arriving after the grant must not appear in the snapshot.
    bus.cnt_intr_reg[6*k +: 6] = bus.cnt_intr_reg[6*k +: 6] | late;
    @(negedge pclk16);
    check("snapshot", {26'd0, bus.vec_status}, {26'd0, stat});
    pulse_ack();
    bus.cnt_intr_reg[6*k +: 6] = late;
    wait_idle();
  endtask

  task automatic do_reset();
    n_p_reset16 = 1'b0;
    repeat (2) @(negedge pclk16);
    check("reset_outs", {17'd0, bus.irq, bus.vec_valid, bus.busy, bus.timeout_err,
                         bus.vec_cnt, bus.vec_status, bus.clear_interrupt}, 32'd0);
    n_p_reset16 = 1'b1;
  endtask

  initial begin
    bus.arb_en = 1'b0; bus.cnt_intr_reg = 18'd0; bus.vec_rd = 1'b0; bus.err_clr = 1'b0;
    do_reset();
    bus.arb_en = 1'b1;

    // Quiet: no requests for 20 cycles.
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk16);
      check("idle_quiet", {29'd0, bus.irq, bus.busy, 1'b0} | {29'd0, bus.clear_interrupt}, 32'd0);
    end

    // Single grant of counter 1 with 1-cycle latency and holdoff of 2.
    @(posedge pclk16); #1 bus.cnt_intr_reg[11:6] = 6'h04;
    exp_grant.push_back({2'd1, 6'h04});
    exp_clr.push_back(3'b010);
    @(negedge pclk16); check("lat_before", {31'd0, bus.irq}, 32'd0);
    @(negedge pclk16); check("lat_irq", {31'd0, bus.irq}, 32'd1);
    repeat (3) @(negedge pclk16);
    pulse_ack();
    bus.cnt_intr_reg[11:6] = 6'h00;
    repeat (3) @(negedge pclk16);
    check("hold_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge pclk16);
    check("hold_done", {31'd0, bus.busy}, 32'd0);

    // Round robin 0,1,2 then wrap back to 0 with re-pended counters.
    do_reset();
    bus.cnt_intr_reg = {6'h20, 6'h02, 6'h01};
    grant_ack(0, 6'h01, 6'h08);
    grant_ack(1, 6'h02, 6'h10);
    grant_ack(2, 6'h20, 6'h01);
    grant_ack(0, 6'h08, 6'h00);
    grant_ack(1, 6'h10, 6'h00);
    grant_ack(2, 6'h01, 6'h00);

    // vec_rd in IDLE is ignored.
    pulse_ack();
    @(negedge pclk16);
    check("rd_idle", {30'd0, bus.busy, bus.irq}, 32'd0);

    // vec_rd in HOLD is ignored (monitor flags any second clear).
    bus.cnt_intr_reg[5:0] = 6'h04;
    exp_grant.push_back({2'd0, 6'h04});
    exp_clr.push_back(3'b001);
    wait_grant();
    pulse_ack();
    bus.cnt_intr_reg[5:0] = 6'h00;
    @(posedge pclk16); #1 bus.vec_rd = 1'b1;
    @(posedge pclk16); #1 bus.vec_rd = 1'b0;
    @(negedge pclk16); check("rd_hold_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge pclk16); check("rd_hold_done", {31'd0, bus.busy}, 32'd0);

    // arb_en dropped during PEND does not withdraw the grant.
    bus.cnt_intr_reg[11:6] = 6'h04;
    exp_grant.push_back({2'd1, 6'h04});
    exp_clr.push_back(3'b010);
    wait_grant();
    bus.arb_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk16);
      check("arb_off_irq", {31'd0, bus.irq}, 32'd1);
    end
    pulse_ack();
    bus.cnt_intr_reg[11:6] = 6'h00;
    bus.arb_en = 1'b1;
    wait_idle();

    // Ack timeout at the 8th PEND cycle, then err_clr, then reset in PEND.
    bus.cnt_intr_reg[17:12] = 6'h02;
    exp_grant.push_back({2'd2, 6'h02});
    wait_grant();
    repeat (6) @(negedge pclk16);
    check("to_p7", {31'd0, bus.timeout_err}, 32'd0);
    @(negedge pclk16);
    check("to_p8", {30'd0, bus.timeout_err, bus.irq}, 32'd3);
    @(posedge pclk16); #1 bus.err_clr = 1'b1;
    @(posedge pclk16); #1 bus.err_clr = 1'b0;
    @(negedge pclk16);
    check("err_clr", {30'd0, bus.timeout_err, bus.irq}, 32'd1);
    #2 n_p_reset16 = 1'b0;
    #1 check("rst_in_pend", {17'd0, bus.irq, bus.vec_valid, bus.busy, bus.timeout_err,
                              bus.vec_cnt, bus.vec_status, bus.clear_interrupt}, 32'd0);
    @(negedge pclk16);
    n_p_reset16 = 1'b1;
    grant_ack(2, 6'h02, 6'h00);

    repeat (3) @(negedge pclk16);
    check("grant_q_empty", exp_grant.size(), 32'd0);
    check("clr_q_empty", exp_clr.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
